// File: rtl/gh_uart_reg_ctrl.sv
// UART register-file bus controller: captures one host access per cs assertion,
// decodes it against DLAB and issues register clock enables, readback and ack.
module gh_uart_reg_ctrl #(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cs,
   input  logic            we,
   input  logic [2:0]      addr,
   input  logic [SIZE-1:0] wdata,
   input  logic [SIZE-1:0] ier_q,
   input  logic [SIZE-1:0] lcr_q,
   input  logic [SIZE-1:0] dll_q,
   input  logic [SIZE-1:0] dlm_q,
   input  logic [SIZE-1:0] scr_q,
   output logic [SIZE-1:0] reg_d,
   output logic            ier_ce,
   output logic            lcr_ce,
   output logic            dll_ce,
   output logic            dlm_ce,
   output logic            scr_ce,
   output logic [SIZE-1:0] rdata,
   output logic            ack,
   output logic            brg_load
);

   // state  | meaning
   // IDLE   | waiting for cs; captures addr/we/wdata when cs=1
   // ACCESS | decode captured address, pulse CE on write, latch rdata on read
   // ACK    | one-cycle ack (and brg_load after a divisor write)
   // HOLD   | wait for cs to drop so one assertion gives one access
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_ACK    = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [2:0]      r_addr;
   logic            r_we;
   logic [SIZE-1:0] r_wdata;
   logic [SIZE-1:0] r_rdata;
   logic            r_brg;
   logic [4:0]      w_sel;   // one-hot {scr, dlm, dll, lcr, ier}
   logic [SIZE-1:0] w_rd_mux;
   logic            w_dlab;

   assign w_dlab = lcr_q[7];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (cs) w_next = S_ACCESS;
         S_ACCESS: w_next = S_ACK;
         S_ACK:    w_next = S_HOLD;
         S_HOLD:   if (!cs) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Outputs are gated by rst so an access cut short by reset writes nothing.
   always_comb begin
      ier_ce   = 1'b0;
      lcr_ce   = 1'b0;
      dll_ce   = 1'b0;
      dlm_ce   = 1'b0;
      scr_ce   = 1'b0;
      ack      = 1'b0;
      brg_load = 1'b0;
      case (r_state)
         S_ACCESS: begin
            if (r_we && !rst) begin
               {scr_ce, dlm_ce, dll_ce, lcr_ce, ier_ce} = w_sel;
            end
         end
         S_ACK: begin
            ack      = !rst;
            brg_load = r_brg && !rst;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_sel = 5'b00000;
      case (r_addr)
         3'd0:    if (w_dlab) w_sel = 5'b00100;
         3'd1:    w_sel = w_dlab ? 5'b01000 : 5'b00001;
         3'd3:    w_sel = 5'b00010;
         3'd7:    w_sel = 5'b10000;
         default: w_sel = 5'b00000;
      endcase
   end

   always_comb begin
      w_rd_mux = '0;
      case (w_sel)
         5'b00001: w_rd_mux = ier_q;
         5'b00010: w_rd_mux = lcr_q;
         5'b00100: w_rd_mux = dll_q;
         5'b01000: w_rd_mux = dlm_q;
         5'b10000: w_rd_mux = scr_q;
         default:  w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= 3'd0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_brg   <= 1'b0;
      end else begin
         if (r_state == S_IDLE && cs) begin
            r_addr  <= addr;
            r_we    <= we;
            r_wdata <= wdata;
         end
         if (r_state == S_ACCESS) begin
            if (!r_we) r_rdata <= w_rd_mux;
            r_brg <= r_we && (w_sel[2] || w_sel[3]);
         end
      end
   end

   assign reg_d = r_wdata;
   assign rdata = r_rdata;

endmodule

// File: tb/tb_gh_uart_reg_ctrl.sv
// Bench for gh_uart_reg_ctrl: table of accesses with a queue of expected
// completions, plus hand sequences for held cs and reset mid-access.
module tb_gh_uart_reg_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs;
   logic       we;
   logic [2:0] addr;
   logic [7:0] wdata;
   logic [7:0] ier_q, lcr_q, dll_q, dlm_q, scr_q;
   logic [7:0] reg_d;
   logic       ier_ce, lcr_ce, dll_ce, dlm_ce, scr_ce;
   logic [7:0] rdata;
   logic       ack;
   logic       brg_load;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       we;
      logic [2:0] addr;
      logic [7:0] wdata;
      logic [7:0] lcr;
      logic [4:0] ce;      // {scr, dlm, dll, lcr, ier}
      logic [7:0] rdata;
      logic       brg;
   } vec_t;

   vec_t vecs [16];
   vec_t exp_q [$];

   always #5 clk = ~clk;

   gh_uart_reg_ctrl #(.SIZE(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .cs       (cs),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .ier_q    (ier_q),
      .lcr_q    (lcr_q),
      .dll_q    (dll_q),
      .dlm_q    (dlm_q),
      .scr_q    (scr_q),
      .reg_d    (reg_d),
      .ier_ce   (ier_ce),
      .lcr_ce   (lcr_ce),
      .dll_ce   (dll_ce),
      .dlm_ce   (dlm_ce),
      .scr_ce   (scr_ce),
      .rdata    (rdata),
      .ack      (ack),
      .brg_load (brg_load)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [4:0] ce_vec();
      return {scr_ce, dlm_ce, dll_ce, lcr_ce, ier_ce};
   endfunction

   task automatic run_access(input vec_t v, input int hold, input string nm);
      int         ce_cnt = 0;
      int         ack_cnt = 0;
      int         brg_cnt = 0;
      int         ce_cyc = -1;
      int         ack_cyc = -1;
      logic [4:0] ce_seen = 5'b0;
      logic [4:0] cur;
      logic [7:0] regd_seen = 8'h00;
      vec_t       e;
      exp_q.push_back(v);
      @(posedge clk); #1;
      cs = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; lcr_q = v.lcr;
      for (int n = 0; n < hold + 4; n++) begin
         @(posedge clk); #1;
         if (n == 0) begin
            we = ~v.we; addr = v.addr ^ 3'b110; wdata = ~v.wdata;
         end
         if (n == hold) cs = 1'b0;
         @(negedge clk);
         cur = ce_vec();
         if (cur != 5'b0) begin
            ce_cnt += $countones(cur);
            ce_seen = cur;
            ce_cyc = n + 1;
            regd_seen = reg_d;
         end
         if (brg_load) brg_cnt++;
         if (ack) begin
            ack_cnt++;
            ack_cyc = n + 1;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL %s.unexpected_ack actual=1 required=0", nm);
            end else begin
               e = exp_q.pop_front();
               chk({nm, ".rdata"}, 32'(rdata), 32'(e.rdata));
               chk({nm, ".brg_at_ack"}, 32'(brg_load), 32'(e.brg));
            end
         end
      end
      if (ack_cnt == 0 && exp_q.size() != 0) void'(exp_q.pop_front());
      chk({nm, ".ack_cnt"}, 32'(ack_cnt), 32'd1);
      chk({nm, ".ack_cycle"}, 32'(ack_cyc), 32'd2);
      chk({nm, ".brg_cnt"}, 32'(brg_cnt), 32'(v.brg));
      chk({nm, ".ce_cnt"}, 32'(ce_cnt), 32'($countones(v.ce)));
      if (v.ce != 5'b0) begin
         chk({nm, ".ce_which"}, 32'(ce_seen), 32'(v.ce));
         chk({nm, ".ce_cycle"}, 32'(ce_cyc), 32'd1);
         chk({nm, ".reg_d"}, 32'(regd_seen), 32'(v.wdata));
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".ce"}, 32'(ce_vec()), 32'd0);
      chk({nm, ".ack"}, 32'(ack), 32'd0);
      chk({nm, ".brg"}, 32'(brg_load), 32'd0);
      chk({nm, ".rdata"}, 32'(rdata), 32'd0);
      chk({nm, ".reg_d"}, 32'(reg_d), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          we    addr  wdata  lcr    ce        rdata  brg
      vecs[0]  = '{1'b1, 3'd3, 8'h83, 8'h00, 5'b00010, 8'h00, 1'b0};
      vecs[1]  = '{1'b1, 3'd0, 8'h0C, 8'h83, 5'b00100, 8'h00, 1'b1};
      vecs[2]  = '{1'b1, 3'd1, 8'h00, 8'h83, 5'b01000, 8'h00, 1'b1};
      vecs[3]  = '{1'b0, 3'd1, 8'h00, 8'h03, 5'b00000, 8'h05, 1'b0};
      vecs[4]  = '{1'b0, 3'd5, 8'h00, 8'h03, 5'b00000, 8'h00, 1'b0};
      vecs[5]  = '{1'b0, 3'd0, 8'h00, 8'h83, 5'b00000, 8'h11, 1'b0};
      vecs[6]  = '{1'b0, 3'd1, 8'h00, 8'h83, 5'b00000, 8'h22, 1'b0};
      vecs[7]  = '{1'b0, 3'd7, 8'h00, 8'h03, 5'b00000, 8'h5A, 1'b0};
      vecs[8]  = '{1'b1, 3'd2, 8'hFF, 8'h00, 5'b00000, 8'h5A, 1'b0};
      vecs[9]  = '{1'b0, 3'd3, 8'h00, 8'h03, 5'b00000, 8'h03, 1'b0};
      vecs[10] = '{1'b0, 3'd0, 8'h00, 8'h03, 5'b00000, 8'h00, 1'b0};
      vecs[11] = '{1'b1, 3'd1, 8'h0F, 8'h03, 5'b00001, 8'h00, 1'b0};
      vecs[12] = '{1'b1, 3'd7, 8'hA5, 8'h83, 5'b10000, 8'h00, 1'b0};
      vecs[13] = '{1'b0, 3'd6, 8'h00, 8'h83, 5'b00000, 8'h00, 1'b0};
      vecs[14] = '{1'b1, 3'd0, 8'h3C, 8'h00, 5'b00000, 8'h00, 1'b0};
      vecs[15] = '{1'b0, 3'd3, 8'h00, 8'h83, 5'b00000, 8'h83, 1'b0};

      rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'h00;
      ier_q = 8'h05; lcr_q = 8'h00; dll_q = 8'h11; dlm_q = 8'h22; scr_q = 8'h5A;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_access(vecs[i], (i == 12) ? 10 : 2, $sformatf("vec%0d", i));
      end

      // Reset lands while a write to SCR sits in ACCESS.
      @(posedge clk); #1;
      cs = 1'b1; we = 1'b1; addr = 3'd7; wdata = 8'hA5; lcr_q = 8'h00;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid.scr_ce", 32'(scr_ce), 32'd0);
      chk("rst_mid.ack", 32'(ack), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("rst_after");
      @(posedge clk);
      @(negedge clk);
      chk("rst_restart.scr_ce", 32'(scr_ce), 32'd1);
      chk("rst_restart.ce", 32'(ce_vec()), 32'b10000);
      chk("rst_restart.reg_d", 32'(reg_d), 32'hA5);
      chk("rst_restart.no_ack", 32'(ack), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_restart.ack", 32'(ack), 32'd1);
      chk("rst_restart.ce_off", 32'(ce_vec()), 32'd0);
      @(posedge clk); #1;
      cs = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_restart.idle_ack", 32'(ack), 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
